// File: rtl/cdc_fifo_pkg.sv
// Shared state type, width helper and fifo_wr_data field layout for the
// write side of the dual-clock FIFO.
package cdc_fifo_pkg;

   typedef enum logic [0:0] {
      FILL = 1'b0,
      HOLD = 1'b1
   } wr_state_e;

   localparam int DATA_LSB = 0;

   // Lane index width; a single-lane word still carries a 1-bit field.
   function automatic int lane_w(input int ratio);
      return (ratio <= 2) ? 1 : $clog2(ratio);
   endfunction

   function automatic int cnt_lsb(input int data_width);
      return DATA_LSB + data_width;
   endfunction

   function automatic int last_bit(input int data_width, input int lanes_w);
      return DATA_LSB + data_width + lanes_w;
   endfunction

endpackage

// File: rtl/cdc_wr_packer_if.sv
// Narrow upstream stream plus wide FIFO write port of the write-side packer.
interface cdc_wr_packer_if #(
   parameter int IN_WIDTH = 32,
   parameter int RATIO    = 4
);
   import cdc_fifo_pkg::*;

   localparam int WORD_W = IN_WIDTH * RATIO + lane_w(RATIO) + 1;

   logic                s_valid;
   logic                s_ready;
   logic [IN_WIDTH-1:0] s_data;
   logic                s_last;
   logic                fifo_wr_en;
   logic [WORD_W-1:0]   fifo_wr_data;
   logic                fifo_full;

   modport master (
      output s_valid, s_data, s_last, fifo_full,
      input  s_ready, fifo_wr_en, fifo_wr_data
   );

   modport slave (
      input  s_valid, s_data, s_last, fifo_full,
      output s_ready, fifo_wr_en, fifo_wr_data
   );

endinterface

// File: rtl/cdc_wr_flush_timer.sv
// Idle counter that expires after FLUSH_CYCLES enabled cycles; FLUSH_CYCLES=0
// never expires.
module cdc_wr_flush_timer #(
   parameter int FLUSH_CYCLES = 16
) (
   input  logic wr_clk,
   input  logic arst_n,
   input  logic clr,
   input  logic en,
   output logic expire
);

   localparam int            CW   = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
   localparam int            TC_I = (FLUSH_CYCLES == 0) ? 0 : FLUSH_CYCLES - 1;
   localparam logic [CW-1:0] TC   = CW'(TC_I);

   logic [CW-1:0] idle_q, idle_d;

   always_comb begin
      expire = (FLUSH_CYCLES != 0) && en && (idle_q == TC);
      idle_d = idle_q;
      if (clr)
         idle_d = '0;
      else if (en && !expire)
         idle_d = idle_q + 1'b1;
   end

   always_ff @(posedge wr_clk or negedge arst_n) begin
      if (!arst_n)
         idle_q <= '0;
      else
         idle_q <= idle_d;
   end

endmodule

// File: rtl/cdc_wr_packer.sv
// Packs RATIO narrow beats into one FIFO word (lane 0 first), sealing early on
// s_last or idle timeout; at most two words buffered (out + asm).
//   state | meaning
//   FILL  | accepting beats into asm; out register may be busy
//   HOLD  | asm holds a sealed word waiting for the out register
module cdc_wr_packer
   import cdc_fifo_pkg::*;
#(
   parameter int IN_WIDTH     = 32,
   parameter int RATIO        = 4,
   parameter int FLUSH_CYCLES = 16
) (
   input  logic           wr_clk,
   input  logic           arst_n,
   cdc_wr_packer_if.slave bus,
   output logic [31:0]    words_written,
   output logic [31:0]    stall_cycles
);

   localparam int                DATA_WIDTH = IN_WIDTH * RATIO;
   localparam int                LANE_W     = lane_w(RATIO);
   localparam int                CNT_LSB    = cnt_lsb(DATA_WIDTH);
   localparam int                LAST_BIT   = last_bit(DATA_WIDTH, LANE_W);
   localparam logic [LANE_W-1:0] LAST_LANE  = LANE_W'(RATIO - 1);

   wr_state_e             state_q, state_d;
   logic [DATA_WIDTH-1:0] asm_data_q, asm_data_d, out_data_q, out_data_d;
   logic [LANE_W-1:0]     asm_cnt_q, asm_cnt_d, out_cnt_q, out_cnt_d;
   logic                  asm_last_q, asm_last_d, out_last_q, out_last_d;
   logic                  out_valid_q, out_valid_d;
   logic [31:0]           words_q, words_d, stall_q, stall_d;

   logic                  wr_en, out_free, accept, ready;
   logic                  seal, seal_last, timer_en, timer_clr, timer_expire;
   logic [DATA_WIDTH-1:0] beat_data, seal_data;
   logic [LANE_W-1:0]     seal_cnt;
   logic [LAST_BIT:0]     wr_word;

   cdc_wr_flush_timer #(.FLUSH_CYCLES(FLUSH_CYCLES)) u_flush_timer (
      .wr_clk (wr_clk),
      .arst_n (arst_n),
      .clr    (timer_clr),
      .en     (timer_en),
      .expire (timer_expire)
   );

   always_comb begin
      ready     = arst_n && (state_q == FILL);
      accept    = bus.s_valid && ready;
      wr_en     = out_valid_q && !bus.fifo_full;
      out_free  = !out_valid_q || wr_en;
      timer_en  = (state_q == FILL) && (asm_cnt_q != '0) && !accept;

      state_d     = state_q;
      asm_data_d  = asm_data_q;
      asm_cnt_d   = asm_cnt_q;
      asm_last_d  = asm_last_q;
      out_data_d  = out_data_q;
      out_cnt_d   = out_cnt_q;
      out_last_d  = out_last_q;
      out_valid_d = out_valid_q && !wr_en;
      seal        = 1'b0;
      seal_data   = asm_data_q;
      seal_cnt    = asm_cnt_q;
      seal_last   = 1'b0;
      beat_data   = asm_data_q;
      beat_data[int'(asm_cnt_q) * IN_WIDTH +: IN_WIDTH] = bus.s_data;

      case (state_q)
         FILL: begin
            if (accept) begin
               if ((asm_cnt_q == LAST_LANE) || bus.s_last) begin
                  seal      = 1'b1;
                  seal_data = beat_data;
                  seal_last = bus.s_last;
               end else begin
                  asm_data_d = beat_data;
                  asm_cnt_d  = asm_cnt_q + 1'b1;
               end
            end else if (timer_expire) begin
               seal     = 1'b1;
               seal_cnt = asm_cnt_q - 1'b1;
            end
            if (seal) begin
               if (out_free) begin
                  out_valid_d = 1'b1;
                  out_data_d  = seal_data;
                  out_cnt_d   = seal_cnt;
                  out_last_d  = seal_last;
                  asm_data_d  = '0;
                  asm_cnt_d   = '0;
                  asm_last_d  = 1'b0;
               end else begin
                  // In HOLD asm_cnt carries lanes_minus1 of the sealed word.
                  asm_data_d = seal_data;
                  asm_cnt_d  = seal_cnt;
                  asm_last_d = seal_last;
                  state_d    = HOLD;
               end
            end
         end
         HOLD: begin
            if (out_free) begin
               out_valid_d = 1'b1;
               out_data_d  = asm_data_q;
               out_cnt_d   = asm_cnt_q;
               out_last_d  = asm_last_q;
               asm_data_d  = '0;
               asm_cnt_d   = '0;
               asm_last_d  = 1'b0;
               state_d     = FILL;
            end
         end
         default: state_d = FILL;
      endcase

      timer_clr = accept || seal;
      words_d   = words_q + 32'(wr_en);
      stall_d   = (out_valid_q && bus.fifo_full && (stall_q != '1)) ? stall_q + 1'b1 : stall_q;

      wr_word                          = '0;
      wr_word[DATA_LSB +: DATA_WIDTH]  = out_data_q;
      wr_word[CNT_LSB +: LANE_W]       = out_cnt_q;
      wr_word[LAST_BIT]                = out_last_q;
   end

   always_ff @(posedge wr_clk or negedge arst_n) begin
      if (!arst_n) begin
         state_q     <= FILL;
         asm_data_q  <= '0;
         asm_cnt_q   <= '0;
         asm_last_q  <= 1'b0;
         out_data_q  <= '0;
         out_cnt_q   <= '0;
         out_last_q  <= 1'b0;
         out_valid_q <= 1'b0;
         words_q     <= '0;
         stall_q     <= '0;
      end else begin
         state_q     <= state_d;
         asm_data_q  <= asm_data_d;
         asm_cnt_q   <= asm_cnt_d;
         asm_last_q  <= asm_last_d;
         out_data_q  <= out_data_d;
         out_cnt_q   <= out_cnt_d;
         out_last_q  <= out_last_d;
         out_valid_q <= out_valid_d;
         words_q     <= words_d;
         stall_q     <= stall_d;
      end
   end

   assign bus.s_ready      = ready;
   assign bus.fifo_wr_en   = wr_en;
   assign bus.fifo_wr_data = wr_word;
   assign words_written    = words_q;
   assign stall_cycles     = stall_q;

endmodule

// File: tb/tb_cdc_wr_packer.sv
// Directed and constrained-random bench for cdc_wr_packer (32-bit beats, 4 lanes).
module tb_cdc_wr_packer;

   localparam int IW = 32;
   localparam int R  = 4;
   localparam int FC = 16;
   localparam int WW = IW * R + 2 + 1;

   logic        wr_clk = 1'b0;
   logic        arst_n = 1'b0;
   logic [31:0] words_written, stall_cycles;

   int n_checks = 0;
   int n_errors = 0;
   int cyc      = 0;
   int acc;
   logic rdy, v;

   logic [WW-1:0] mon_q[$];
   int            mon_t[$];
   logic [WW-1:0] exp_q[$];

   logic [31:0] beat  [400];
   bit          lastb [400];

   cdc_wr_packer_if #(.IN_WIDTH(IW), .RATIO(R)) bus ();

   cdc_wr_packer #(.IN_WIDTH(IW), .RATIO(R), .FLUSH_CYCLES(FC)) dut (
      .wr_clk        (wr_clk),
      .arst_n        (arst_n),
      .bus           (bus),
      .words_written (words_written),
      .stall_cycles  (stall_cycles)
   );

   always #5 wr_clk = ~wr_clk;

   always @(negedge wr_clk) begin
      cyc = cyc + 1;
      if (bus.fifo_wr_en === 1'b1) begin
         mon_q.push_back(bus.fifo_wr_data);
         mon_t.push_back(cyc);
      end
   end

   task automatic chk(input string tag, input logic [WW-1:0] got, input logic [WW-1:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [WW-1:0] mk_word(input bit last, input logic [1:0] c,
                                             input logic [31:0] l3, input logic [31:0] l2,
                                             input logic [31:0] l1, input logic [31:0] l0);
      return {last, c, l3, l2, l1, l0};
   endfunction

   task automatic tick();
      @(posedge wr_clk);
      #1;
   endtask

   task automatic send(input logic [31:0] d, input bit l);
      int n = 0;
      bus.s_valid = 1'b1;
      bus.s_data  = d;
      bus.s_last  = l;
      while (!bus.s_ready && n < 200) begin
         tick();
         n++;
      end
      if (!bus.s_ready) chk("send_timeout", 0, 1);
      tick();
      bus.s_valid = 1'b0;
      bus.s_last  = 1'b0;
   endtask

   task automatic clear_mon();
      mon_q.delete();
      mon_t.delete();
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.s_valid   = 1'b0;
      bus.s_data    = '0;
      bus.s_last    = 1'b0;
      bus.fifo_full = 1'b0;

      // reset state
      tick(); tick();
      chk("rst_s_ready", bus.s_ready, 0);
      chk("rst_wr_en", bus.fifo_wr_en, 0);
      chk("rst_wr_data", bus.fifo_wr_data, 0);
      arst_n = 1'b1;
      tick();
      chk("rel_s_ready", bus.s_ready, 1);
      chk("rel_words", words_written, 0);
      chk("rel_stall", stall_cycles, 0);

      // full word, back-to-back
      clear_mon();
      send(32'h11, 0); send(32'h22, 0); send(32'h33, 0); send(32'h44, 0);
      chk("t1_wr_en", bus.fifo_wr_en, 1);
      chk("t1_data", bus.fifo_wr_data, mk_word(0, 2'd3, 32'h44, 32'h33, 32'h22, 32'h11));
      tick();
      chk("t1_wr_en_drop", bus.fifo_wr_en, 0);
      chk("t1_words", words_written, 1);
      chk("t1_pulses", mon_q.size(), 1);

      // s_last seal, then a clean full word
      send(32'hA, 0); send(32'hB, 1);
      chk("t2_wr_en", bus.fifo_wr_en, 1);
      chk("t2_data", bus.fifo_wr_data, mk_word(1, 2'd1, 0, 0, 32'hB, 32'hA));
      chk("t2_ready", bus.s_ready, 1);
      tick();
      send(32'h1, 0); send(32'h2, 0); send(32'h3, 0); send(32'h4, 0);
      chk("t2_clean", bus.fifo_wr_data, mk_word(0, 2'd3, 32'h4, 32'h3, 32'h2, 32'h1));
      tick();
      chk("t2_words", words_written, 3);

      // backpressure: two words buffered, then drain in order
      clear_mon();
      bus.fifo_full = 1'b1;
      acc = 0;
      for (int c = 0; c < 20; c++) begin
         bus.s_valid = (acc < 12);
         bus.s_data  = 32'h100 + acc;
         rdy = bus.s_ready; v = bus.s_valid;
         tick();
         if (v && rdy) acc++;
      end
      chk("t3_accepts_full", acc, 8);
      chk("t3_ready_low", bus.s_ready, 0);
      chk("t3_stall16", stall_cycles, 16);
      chk("t3_no_write", mon_q.size(), 0);
      tick();
      chk("t3_stall17", stall_cycles, 17);
      bus.fifo_full = 1'b0;
      #1;
      chk("t3_hold_ready", bus.s_ready, 0);
      chk("t3_drain_en", bus.fifo_wr_en, 1);
      for (int c = 0; c < 12; c++) begin
         bus.s_valid = (acc < 12);
         bus.s_data  = 32'h100 + acc;
         rdy = bus.s_ready; v = bus.s_valid;
         tick();
         if (v && rdy) acc++;
         if (c == 0) chk("t3_ready_after", bus.s_ready, 1);
      end
      bus.s_valid = 1'b0;
      tick(); tick();
      chk("t3_accepts", acc, 12);
      chk("t3_nwords", mon_q.size(), 3);
      if (mon_q.size() == 3) begin
         chk("t3_w0", mon_q[0], mk_word(0, 2'd3, 32'h103, 32'h102, 32'h101, 32'h100));
         chk("t3_w1", mon_q[1], mk_word(0, 2'd3, 32'h107, 32'h106, 32'h105, 32'h104));
         chk("t3_w2", mon_q[2], mk_word(0, 2'd3, 32'h10B, 32'h10A, 32'h109, 32'h108));
         chk("t3_consec", mon_t[1] - mon_t[0], 1);
      end
      chk("t3_stall_final", stall_cycles, 17);

      // idle flush after FC cycles
      clear_mon();
      send(32'hC1, 0); send(32'hC2, 0); send(32'hC3, 0);
      repeat (15) tick();
      chk("t4_no_early", mon_q.size(), 0);
      chk("t4_en_early", bus.fifo_wr_en, 0);
      tick();
      chk("t4_flush_en", bus.fifo_wr_en, 1);
      chk("t4_flush_data", bus.fifo_wr_data, mk_word(0, 2'd2, 0, 32'hC3, 32'hC2, 32'hC1));
      tick();
      clear_mon();
      send(32'hD1, 0); send(32'hD2, 0);
      repeat (14) tick();
      send(32'hD3, 0);
      repeat (15) tick();
      chk("t4_restart_none", mon_q.size(), 0);
      tick();
      chk("t4_restart_en", bus.fifo_wr_en, 1);
      chk("t4_restart_data", bus.fifo_wr_data, mk_word(0, 2'd2, 0, 32'hD3, 32'hD2, 32'hD1));
      tick();

      // reset mid-operation
      clear_mon();
      bus.fifo_full = 1'b1;
      send(32'hE0, 0); send(32'hE1, 0); send(32'hE2, 0); send(32'hE3, 0);
      send(32'hE4, 0); send(32'hE5, 0);
      tick();
      arst_n = 1'b0;
      bus.fifo_full = 1'b0;
      #1;
      chk("t5_rst_ready", bus.s_ready, 0);
      chk("t5_rst_en", bus.fifo_wr_en, 0);
      repeat (3) tick();
      chk("t5_rst_none", mon_q.size(), 0);
      arst_n = 1'b1;
      #1;
      chk("t5_rel_ready", bus.s_ready, 1);
      chk("t5_rel_words", words_written, 0);
      chk("t5_rel_stall", stall_cycles, 0);
      chk("t5_rel_data", bus.fifo_wr_data, 0);
      send(32'hF0, 0); send(32'hF1, 0); send(32'hF2, 0); send(32'hF3, 0);
      chk("t5_clean", bus.fifo_wr_data, mk_word(0, 2'd3, 32'hF3, 32'hF2, 32'hF1, 32'hF0));
      tick();
      chk("t5_nwords", mon_q.size(), 1);

      // random stream with random backpressure
      arst_n = 1'b0;
      tick();
      arst_n = 1'b1;
      tick();
      clear_mon();
      for (int i = 0; i < 400; i++) begin
         beat[i]  = $urandom;
         lastb[i] = (i == 399) || ($urandom_range(0, 6) == 0);
      end
      begin
         int idx = 0;
         int budget = 0;
         int ln = 0;
         logic [IW*R-1:0] acc_data = '0;
         while (idx < 400 && budget < 6000) begin
            v = ($urandom_range(0, 4) != 0);
            bus.s_valid   = v;
            bus.s_data    = beat[idx];
            bus.s_last    = lastb[idx];
            bus.fifo_full = ($urandom_range(0, 9) < 3);
            rdy = bus.s_ready;
            tick();
            budget++;
            if (v && rdy) begin
               acc_data[ln*IW +: IW] = beat[idx];
               if (ln == R - 1 || lastb[idx]) begin
                  exp_q.push_back({lastb[idx], 2'(ln), acc_data});
                  acc_data = '0;
                  ln = 0;
               end else begin
                  ln++;
               end
               idx++;
            end
         end
         if (idx < 400) chk("t6_timeout", idx, 400);
      end
      bus.s_valid   = 1'b0;
      bus.s_last    = 1'b0;
      bus.fifo_full = 1'b0;
      repeat (10) tick();
      chk("t6_nwords", mon_q.size(), exp_q.size());
      chk("t6_words_written", words_written, exp_q.size());
      for (int i = 0; i < exp_q.size() && i < mon_q.size(); i++)
         chk($sformatf("t6_word%0d", i), mon_q[i], exp_q[i]);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
